// File: rtl/audio_pkg.sv
// Shared definitions for the envelope streamer: default sizes, the envelope
// record layout and the FSM state encoding.
package audio_pkg;

    localparam int DATA_W_DEF        = 32;
    localparam int NUM_INTERVALS_DEF = 10;
    localparam int IDX_W_DEF         = $clog2(NUM_INTERVALS_DEF);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // One streamed record at the default sizes; p2p is one bit wider than the operands.
    typedef struct packed {
        logic [IDX_W_DEF-1:0]  index;
        logic [DATA_W_DEF-1:0] amp_min;
        logic [DATA_W_DEF-1:0] amp_max;
        logic [DATA_W_DEF:0]   p2p;
    } env_rec_t;

endpackage

// File: rtl/audio_envelope_streamer_buffer.sv
// Interval record store: one synchronous write port, one combinational read
// port. Contents are not reset; only slots below the fill count are ever read.
module envelope_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_min,
    input  logic [DATA_W-1:0] wr_max,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_min,
    output logic [DATA_W-1:0] rd_max
);

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [2*DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= {wr_max, wr_min};
        end
    end

    // Addresses past the end (possible when DEPTH is not a power of two) read as zero.
    assign rd_word = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    assign rd_min  = rd_word[DATA_W-1:0];
    assign rd_max  = rd_word[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/audio_envelope_streamer.sv
// Buffers one frame of (min, max) interval pairs and streams them out as
// {index, min, max, p2p} records over a valid/ready handshake.
//
// state     | meaning
// ST_IDLE   | accepting pairs and wr_done; waiting for start
// ST_STREAM | output registers hold a record; advancing on each handshake
module audio_envelope_streamer
    import audio_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int NUM_INTERVALS = NUM_INTERVALS_DEF,
    parameter int IDX_W         = $clog2(NUM_INTERVALS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_min,
    input  logic [DATA_W-1:0] wr_max,
    input  logic              wr_done,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W:0]   out_p2p,
    output logic              out_last,
    output logic              busy,
    output logic [IDX_W:0]    count,
    output logic              overflow
);

    localparam logic [IDX_W:0] FULL      = (IDX_W+1)'(NUM_INTERVALS);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t              state, state_nxt;
    logic                frame_ready, frame_ready_nxt;
    logic                overflow_nxt;
    logic [IDX_W:0]      count_nxt;
    logic                out_valid_nxt, out_last_nxt;
    logic [IDX_W-1:0]    out_index_nxt;
    logic [DATA_W-1:0]   out_min_nxt, out_max_nxt;
    logic [DATA_W:0]     out_p2p_nxt;

    logic                buf_we;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    rd_addr;
    logic [DATA_W-1:0]   rd_min, rd_max;
    logic [DATA_W:0]     rd_p2p;
    logic                handshake;

    envelope_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_INTERVALS),
        .ADDR_W (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (count[IDX_W-1:0]),
        .wr_min  (wr_min),
        .wr_max  (wr_max),
        .rd_addr (rd_addr),
        .rd_min  (rd_min),
        .rd_max  (rd_max)
    );

    assign handshake = out_valid & out_ready;
    assign next_idx  = out_index + IDX_ONE;
    // In IDLE the read port is parked on slot 0 so the first record is ready at start.
    assign rd_addr   = (state == ST_STREAM) ? next_idx : '0;
    // Sign-extend both operands first so the difference can never overflow.
    assign rd_p2p    = {rd_max[DATA_W-1], rd_max} - {rd_min[DATA_W-1], rd_min};
    assign busy      = (state == ST_STREAM);

    always_comb begin
        state_nxt       = state;
        frame_ready_nxt = frame_ready;
        overflow_nxt    = overflow;
        count_nxt       = count;
        out_valid_nxt   = out_valid;
        out_last_nxt    = out_last;
        out_index_nxt   = out_index;
        out_min_nxt     = out_min;
        out_max_nxt     = out_max;
        out_p2p_nxt     = out_p2p;
        buf_we          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wr_en) begin
                    if (count < FULL) begin
                        buf_we    = 1'b1;
                        count_nxt = count + CNT_ONE;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end
                if (wr_done) begin
                    frame_ready_nxt = 1'b1;
                end
                if (start && frame_ready && (count != '0)) begin
                    state_nxt     = ST_STREAM;
                    out_valid_nxt = 1'b1;
                    out_index_nxt = '0;
                    out_min_nxt   = rd_min;
                    out_max_nxt   = rd_max;
                    out_p2p_nxt   = rd_p2p;
                    // A pair written on the start cycle still joins the frame.
                    out_last_nxt  = (count_nxt == CNT_ONE);
                end
            end

            ST_STREAM: begin
                if (wr_en) begin
                    overflow_nxt = 1'b1;
                end
                if (handshake) begin
                    if (out_last) begin
                        state_nxt       = ST_IDLE;
                        count_nxt       = '0;
                        frame_ready_nxt = 1'b0;
                        out_valid_nxt   = 1'b0;
                        out_last_nxt    = 1'b0;
                    end else begin
                        out_index_nxt = next_idx;
                        out_min_nxt   = rd_min;
                        out_max_nxt   = rd_max;
                        out_p2p_nxt   = rd_p2p;
                        out_last_nxt  = ({1'b0, next_idx} == (count - CNT_ONE));
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            frame_ready <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_index   <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_p2p     <= '0;
        end else begin
            state       <= state_nxt;
            frame_ready <= frame_ready_nxt;
            overflow    <= overflow_nxt;
            count       <= count_nxt;
            out_valid   <= out_valid_nxt;
            out_last    <= out_last_nxt;
            out_index   <= out_index_nxt;
            out_min     <= out_min_nxt;
            out_max     <= out_max_nxt;
            out_p2p     <= out_p2p_nxt;
        end
    end

endmodule

// File: tb/tb_audio_envelope_streamer.sv
// Directed vector bench for audio_envelope_streamer: a table of per-cycle
// stimulus and expected outputs, plus a mid-stream reset sequence.
module tb_audio_envelope_streamer;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] wr_min, wr_max;
    logic        wr_done, start, out_ready;
    logic        out_valid, out_last, busy, overflow;
    logic [3:0]  out_index;
    logic [31:0] out_min, out_max;
    logic [32:0] out_p2p;
    logic [4:0]  count;

    int vectors     = 0;
    int miscompares = 0;

    audio_envelope_streamer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_min    (wr_min),
        .wr_max    (wr_max),
        .wr_done   (wr_done),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_p2p   (out_p2p),
        .out_last  (out_last),
        .busy      (busy),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] mn, mx;
        logic        dn, st, rd;
        logic        e_valid;
        logic [3:0]  e_index;
        logic [31:0] e_min, e_max;
        logic [32:0] e_p2p;
        logic        e_last;
        logic        e_busy;
        logic [4:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idl(string tag, logic we, logic [31:0] mn, logic [31:0] mx,
                                 logic dn, logic st, logic rd, int cnt, logic eo);
        vec_t t;
        t.tag = tag; t.we = we; t.mn = mn; t.mx = mx; t.dn = dn; t.st = st; t.rd = rd;
        t.e_valid = 1'b0; t.e_index = '0; t.e_min = '0; t.e_max = '0; t.e_p2p = '0;
        t.e_last = 1'b0; t.e_busy = 1'b0; t.e_count = 5'(cnt); t.e_ovf = eo;
        return t;
    endfunction

    function automatic vec_t rec(string tag, logic we, logic dn, logic st, logic rd,
                                 int idx, logic [31:0] emn, logic [31:0] emx, logic [32:0] ep,
                                 logic el, int cnt, logic eo);
        vec_t t;
        t.tag = tag; t.we = we; t.mn = 32'h0; t.mx = 32'h0; t.dn = dn; t.st = st; t.rd = rd;
        t.e_valid = 1'b1; t.e_index = 4'(idx); t.e_min = emn; t.e_max = emx; t.e_p2p = ep;
        t.e_last = el; t.e_busy = 1'b1; t.e_count = 5'(cnt); t.e_ovf = eo;
        return t;
    endfunction

    task automatic check_vec(input vec_t t);
        logic bad;
        bad = 1'b0;
        if (out_valid !== t.e_valid || busy !== t.e_busy || count !== t.e_count ||
            overflow !== t.e_ovf || out_last !== t.e_last)
            bad = 1'b1;
        if (t.e_valid && (out_index !== t.e_index || out_min !== t.e_min ||
                          out_max !== t.e_max || out_p2p !== t.e_p2p))
            bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%b i=%0d min=%h max=%h p2p=%h last=%b busy=%b cnt=%0d ovf=%b | want v=%b i=%0d min=%h max=%h p2p=%h last=%b busy=%b cnt=%0d ovf=%b",
                     t.tag, out_valid, out_index, out_min, out_max, out_p2p, out_last, busy, count, overflow,
                     t.e_valid, t.e_index, t.e_min, t.e_max, t.e_p2p, t.e_last, t.e_busy, t.e_count, t.e_ovf);
        end
    endtask

    task automatic run_vec(input vec_t t);
        @(negedge clk);
        wr_en = t.we; wr_min = t.mn; wr_max = t.mx;
        wr_done = t.dn; start = t.st; out_ready = t.rd;
        @(posedge clk);
        #1;
        check_vec(t);
    endtask

    task automatic check_cleared(input string tag);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 ||
            out_last !== 1'b0 || out_index !== 4'd0 || out_min !== 32'd0 ||
            out_max !== 32'd0 || out_p2p !== 33'd0) begin
            miscompares++;
            $display("FAIL %s: got v=%b busy=%b cnt=%0d ovf=%b last=%b i=%0d min=%h max=%h p2p=%h, want all zero",
                     tag, out_valid, busy, count, overflow, out_last, out_index, out_min, out_max, out_p2p);
        end
    endtask

    initial begin
        wr_en = 0; wr_min = 0; wr_max = 0; wr_done = 0; start = 0; out_ready = 0;
        reset_n = 1'b0;

        // T1: full frame, ready held high
        for (int k = 1; k <= 10; k++)
            vecs.push_back(idl("t1_write", 1, 32'(-k), 32'(k), k == 10, 0, 0, k, 0));
        vecs.push_back(rec("t1_rec", 0, 0, 1, 1, 0, 32'(-1), 32'd1, 33'd2, 0, 10, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(rec("t1_rec", 0, 0, 0, 1, i, 32'(-(i+1)), 32'(i+1), 33'(2*(i+1)), i == 9, 10, 0));
        vecs.push_back(idl("t1_end", 0, 0, 0, 0, 0, 1, 0, 0));

        // T2: same frame, ready alternating; stall cycles also poke start and wr_done
        for (int k = 1; k <= 10; k++)
            vecs.push_back(idl("t2_write", 1, 32'(-k), 32'(k), k == 10, 0, 0, k, 0));
        vecs.push_back(rec("t2_start", 0, 0, 1, 0, 0, 32'(-1), 32'd1, 33'd2, 0, 10, 0));
        for (int i = 0; i <= 9; i++) begin
            vecs.push_back(rec("t2_stall", 0, 1, 1, 0, i, 32'(-(i+1)), 32'(i+1), 33'(2*(i+1)), i == 9, 10, 0));
            if (i < 9)
                vecs.push_back(rec("t2_go", 0, 0, 0, 1, i+1, 32'(-(i+2)), 32'(i+2), 33'(2*(i+2)), (i+1) == 9, 10, 0));
            else
                vecs.push_back(idl("t2_end", 0, 0, 0, 0, 0, 1, 0, 0));
        end

        // T4a: start before wr_done is ignored (wr_done seen during T2's stream must not count)
        vecs.push_back(idl("t4_write", 1, 32'd5, 32'd6, 0, 0, 0, 1, 0));
        vecs.push_back(idl("t4_write", 1, 32'(-3), 32'(-8), 0, 0, 0, 2, 0));
        vecs.push_back(idl("t4_start_no_done", 0, 0, 0, 0, 1, 1, 2, 0));
        vecs.push_back(idl("t4_done", 0, 0, 0, 1, 0, 1, 2, 0));
        vecs.push_back(rec("t4_rec", 0, 0, 1, 1, 0, 32'd5, 32'd6, 33'd1, 0, 2, 0));
        vecs.push_back(rec("t4_rec_neg", 0, 0, 0, 1, 1, 32'(-3), 32'(-8), 33'(-5), 1, 2, 0));
        vecs.push_back(idl("t4_end", 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(idl("t4_start_empty", 0, 0, 0, 0, 1, 1, 0, 0));

        // T3: 11 writes, the 11th is dropped and overflow latches
        for (int k = 1; k <= 11; k++)
            vecs.push_back(idl("t3_write", 1, 32'(k), 32'(10*k), k == 11, 0, 0, (k > 10) ? 10 : k, k == 11));
        for (int i = 0; i <= 9; i++)
            vecs.push_back(rec("t3_rec", 0, 0, i == 0, 1, i, 32'(i+1), 32'(10*(i+1)), 33'(9*(i+1)), i == 9, 10, 1));
        vecs.push_back(idl("t3_end", 0, 0, 0, 0, 0, 1, 0, 1));

        // T4b: start with an empty buffer, with and without frame_ready
        vecs.push_back(idl("t4_done_start_empty", 0, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(idl("t4_ready_empty", 0, 0, 0, 0, 1, 1, 0, 1));

        // T5: full-scale extremes
        vecs.push_back(idl("t5_write", 1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 1, 1));
        vecs.push_back(idl("t5_write", 1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0, 2, 1));
        vecs.push_back(rec("t5_p2p_neg", 0, 0, 1, 1, 0, 32'h7FFF_FFFF, 32'h8000_0000, 33'h1_0000_0001, 0, 2, 1));
        vecs.push_back(rec("t5_p2p_pos", 0, 0, 0, 1, 1, 32'h8000_0000, 32'h7FFF_FFFF, 33'h0_FFFF_FFFF, 1, 2, 1));
        vecs.push_back(idl("t5_end", 0, 0, 0, 0, 0, 1, 0, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_cleared("reset_state");

        foreach (vecs[n]) run_vec(vecs[n]);

        // Mid-stream reset: stream a 10-pair frame and pull reset while record 4 is presented
        for (int k = 1; k <= 10; k++)
            run_vec(idl("rst_write", 1, 32'(-k), 32'(k), k == 10, 0, 0, k, 1));
        run_vec(rec("rst_rec", 0, 0, 1, 1, 0, 32'(-1), 32'd1, 33'd2, 0, 10, 1));
        for (int i = 1; i <= 4; i++)
            run_vec(rec("rst_rec", 0, 0, 0, 1, i, 32'(-(i+1)), 32'(i+1), 33'(2*(i+1)), 0, 10, 1));
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_cleared("async_reset_midstream");
        @(negedge clk);
        wr_en = 0; wr_done = 0; start = 0; out_ready = 0;
        reset_n = 1'b1;

        // Fresh 3-pair frame; a write during the stream is dropped and sets overflow
        for (int k = 1; k <= 3; k++)
            run_vec(idl("post_rst_write", 1, 32'(k), 32'(3*k), k == 3, 0, 0, k, 0));
        run_vec(rec("post_rst_rec0", 0, 0, 1, 0, 0, 32'd1, 32'd3, 33'd2, 0, 3, 0));
        begin
            vec_t t;
            t = rec("stream_write_dropped", 1, 0, 0, 0, 0, 32'd1, 32'd3, 33'd2, 0, 3, 1);
            t.mn = 32'hDEAD_0000;
            t.mx = 32'h0000_BEEF;
            run_vec(t);
        end
        run_vec(rec("post_rst_rec1", 0, 0, 0, 1, 1, 32'd2, 32'd6, 33'd4, 0, 3, 1));
        run_vec(rec("post_rst_rec2", 0, 0, 0, 1, 2, 32'd3, 32'd9, 33'd6, 1, 3, 1));
        run_vec(idl("post_rst_end", 0, 0, 0, 0, 0, 1, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_envelope_streamer.md
# audio_envelope_streamer

Receives per-interval (min, max) amplitude pairs from the interval min/max engine, buffers one frame of them, and on request streams them to a downstream consumer over a valid/ready handshake. Each record carries the interval index, min, max and peak-to-peak value. It is the reader end of the envelope results, between the min/max engine and display/transport logic.

## Interface
Parameters:
- DATA_W, 32, sample/amplitude width (signed two's complement)
- NUM_INTERVALS, 10, buffer depth in interval records
- IDX_W, $clog2(NUM_INTERVALS), index width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  push one (min, max) pair this cycle
- wr_min  in  DATA_W  signed interval minimum
- wr_max  in  DATA_W  signed interval maximum
- wr_done  in  1  engine frame-complete indication, sampled as a level
- start  in  1  request to stream the buffered frame
- out_valid  out  1  output record valid
- out_ready  in  1  consumer accepts record
- out_index  out  IDX_W  interval index of record
- out_min  out  DATA_W  signed min
- out_max  out  DATA_W  signed max
- out_p2p  out  DATA_W+1  signed max − min
- out_last  out  1  record is last of frame
- busy  out  1  high in STREAM
- count  out  IDX_W+1  pairs currently buffered
- overflow  out  1  sticky: a write was dropped

## Operation
- States: IDLE, STREAM. Reset → IDLE. All outputs and count 0, frame_ready and overflow cleared, buffer contents don't-care.
- IDLE write: wr_en with count < NUM_INTERVALS stores the pair at slot count, then count+1. wr_en with count == NUM_INTERVALS drops the pair and sets overflow.
- wr_done high in IDLE sets internal frame_ready. A same-cycle wr_en is stored and is part of the frame.
- IDLE → STREAM: start && frame_ready && count > 0. Otherwise start is ignored. This includes start with count == 0 and start before wr_done.
- STREAM: the output registers hold record i = {i, min[i], max[i], max[i] − min[i]}, with out_last = (i == count−1). On out_valid && out_ready, record i+1 is loaded. After the last handshake: → IDLE; count, frame_ready, out_valid, out_last cleared.
- wr_en in STREAM is dropped and sets overflow. wr_done in STREAM is ignored. start in STREAM is ignored.
- p2p arithmetic: both operands sign-extended to DATA_W+1 before subtraction, so there is no overflow. A pair with min > max is stored unchanged and yields a negative p2p.
- overflow clears only on reset.

## Timing
- Start is sampled at edge k. out_valid, index 0 and its data are visible after edge k, a latency of 1 cycle.
- Throughput is 1 record/cycle while out_ready is held high.
- With out_valid high, out_* are stable until the handshake. out_valid never drops without a handshake.
- A frame of N records with out_ready held high completes in N cycles. busy falls at the edge of the last handshake.
- A new frame may be written on the cycle after returning to IDLE.
- reset_n low mid-stream clears out_valid and all outputs asynchronously, with no partial record. After release the block is in IDLE with count 0.

## Structure
- Shared package audio_pkg: DATA_W and NUM_INTERVALS defaults, the envelope record typedef {index, min, max, p2p}, and state encoding constants.
- One natural sub-module: envelope_buffer. It is a NUM_INTERVALS × 2·DATA_W register file with a write port and an asynchronous read port. The top level holds the FSM, counters and output registers.

## Test plan
- Write 10 pairs (min=−k, max=k, k=1..10), assert wr_done, start, out_ready=1 → 10 consecutive records, index 0..9, p2p=2k, out_last only on index 9, busy low after.
- Same frame with out_ready toggling 1/0 each cycle → records held stable while stalled, all 10 delivered in order, no duplicates.
- Write 11 pairs → count=10, overflow=1. The 11th pair is absent from the stream.
- Start with count=0, and separately start before wr_done → out_valid stays 0, state IDLE.
- Pair min=0x7FFFFFFF, max=0x80000000 → out_p2p = −0xFFFFFFFF (33-bit signed). Pair min=0x80000000, max=0x7FFFFFFF → out_p2p = 0x0FFFFFFFF.
- Assert reset_n low during record 4 of 10 → out_valid, busy, count zero immediately. A fresh 3-pair frame then streams indices 0..2 correctly.
